// File: rtl/ram_sr_sw_initiator.sv
// Burst initiator for one port of a synchronous-read/synchronous-write chip-select RAM.
// Turns valid/ready burst commands into cs/we/oe cycles with auto-incrementing addresses.
module ram_sr_sw_initiator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [2:0] {StIdle, StWr, StRdIssue, StRdDrain, StTurn} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cs_d, we_d, oe_d;
  // Marks the cycle in which the RAM's registered read data is on the bus.
  logic                  cap_q, cap_d;
  logic                  cap_last_q, cap_last_d;

  assign cmd_ready = (state_q == StIdle);
  assign wr_ready  = (state_q == StWr);
  assign mem_data  = (mem_cs && mem_we) ? wdata_q : 'z;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    mem_address_d = mem_address;
    wdata_d       = wdata_q;
    cs_d          = 1'b0;
    we_d          = 1'b0;
    oe_d          = 1'b0;
    cap_d         = 1'b0;
    cap_last_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          if (cmd_we) begin
            state_d = StWr;
          end else begin
            state_d       = StRdIssue;
            cs_d          = 1'b1;
            oe_d          = 1'b1;
            mem_address_d = cmd_addr;
          end
        end
      end
      StWr: begin
        if (wr_valid) begin
          cs_d          = 1'b1;
          we_d          = 1'b1;
          mem_address_d = addr_q;
          wdata_d       = wr_data;
          addr_d        = addr_q + ADDR_WIDTH'(1);
          if (cnt_q == '0) state_d = StIdle;
          else             cnt_d   = cnt_q - LEN_WIDTH'(1);
        end
      end
      StRdIssue: begin
        cap_d      = 1'b1;
        cap_last_d = (cnt_q == '0);
        cs_d       = 1'b1;
        oe_d       = 1'b1;
        if (cnt_q == '0) begin
          // Hold strobes and address one more cycle so the last beat stays on the bus.
          state_d = StRdDrain;
        end else begin
          cnt_d         = cnt_q - LEN_WIDTH'(1);
          mem_address_d = mem_address + ADDR_WIDTH'(1);
        end
      end
      StRdDrain: begin
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        state_d = StTurn;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_address <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      cap_q       <= 1'b0;
      cap_last_q  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_address <= mem_address_d;
      mem_cs      <= cs_d;
      mem_we      <= we_d;
      mem_oe      <= oe_d;
      cap_q       <= cap_d;
      cap_last_q  <= cap_last_d;
      rd_valid    <= cap_q;
      rd_last     <= cap_q && cap_last_q;
      busy        <= (state_d != StIdle);
      if (cap_q) rd_data <= mem_data;
    end
  end

endmodule
